// File: rtl/adder_serial.sv
// Digit-serial adder/subtractor: operands captured on start, summed DIGIT bits per
// clock LSB-first through a registered carry; result, carry-out and overflow held.
module adder_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("adder_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // B already inverted for subtract
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_shift;
  logic             msb_cin;
  logic             last;
  logic             load;

  assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
  assign last    = (cnt_q == CW'(N - 1));
  assign load    = start && (state_q != S_RUN);

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_shift = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign res_shift = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_shift;
        cy_d  = dsum[DIGIT];
        if (last) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          c_out_d = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture overrides the DONE->IDLE return, giving back-to-back operation.
    if (load) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      cy_d    = sub ^ c_in;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_serial.sv
// Directed checks of adder_serial (WIDTH=8, DIGIT=2) plus an exhaustive 4-bit sweep
// against a signed/unsigned arithmetic reference for DIGIT=1, 2 and 4.
module tb_adder_serial;

  logic       Clk;
  logic       Reset_n;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic [2:0] busy4, done4, cout4, ovf4;
  logic [3:0] sum4 [3];

  int checks   = 0;
  int failures = 0;

  adder_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8));

  adder_serial #(.WIDTH(4), .DIGIT(1)) u_dut4_d1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .c_out(cout4[0]), .overflow(ovf4[0]));

  adder_serial #(.WIDTH(4), .DIGIT(2)) u_dut4_d2 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .c_out(cout4[1]), .overflow(ovf4[1]));

  adder_serial #(.WIDTH(4), .DIGIT(4)) u_dut4_d4 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .c_out(cout4[2]), .overflow(ovf4[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    a8 = av; b8 = bv; cin8 = cv; sub8 = sv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hxx; b8 = 8'hxx; cin8 = 1'bx; sub8 = 1'bx;
  endtask

  // Called just after the start edge t; returns just after edge t+4 (the done cycle).
  task automatic run_check8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, "_busy_t"}, {30'd0, busy8, done8}, 32'h2);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, "_busy_run"}, {30'd0, busy8, done8}, 32'h2);
    end
    tick();
    check({tag, "_done"}, {30'd0, busy8, done8}, 32'h1);
    check({tag, "_result"}, {22'd0, ovf8, cout8, sum8}, {22'd0, eo, ec, es});
  endtask

  task automatic check_hold8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    check({tag, "_idle"}, {30'd0, busy8, done8}, 32'h0);
    check({tag, "_held"}, {22'd0, ovf8, cout8, sum8}, {22'd0, eo, ec, es});
  endtask

  initial begin
    logic [5:0] obs [3];
    logic [5:0] exp4;
    logic [2:0] got;
    int r, sa, sb, rs;

    Reset_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    #1;
    check("reset_outputs", {19'd0, busy8, done8, ovf8, cout8, sum8}, 32'h0);
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    check("idle_after_reset", {19'd0, busy8, done8, ovf8, cout8, sum8}, 32'h0);

    // Add, signed overflow
    start_op8(8'h3C, 8'h47, 1'b0, 1'b0);
    run_check8("add_3c_47", 8'h83, 1'b0, 1'b1);
    tick();
    check_hold8("add_3c_47_post", 8'h83, 1'b0, 1'b1);

    // Add with carry wrap
    start_op8(8'hFF, 8'h01, 1'b1, 1'b0);
    run_check8("add_ff_01_c1", 8'h01, 1'b1, 1'b0);
    tick();
    check_hold8("add_ff_01_post", 8'h01, 1'b1, 1'b0);

    // Subtract with borrow out
    start_op8(8'h10, 8'h20, 1'b0, 1'b1);
    run_check8("sub_10_20", 8'hF0, 1'b0, 1'b0);
    tick();

    // Subtract with signed overflow
    start_op8(8'h80, 8'h01, 1'b0, 1'b1);
    run_check8("sub_80_01", 8'h7F, 1'b1, 1'b1);
    tick();

    // Subtract with borrow-in
    start_op8(8'h50, 8'h20, 1'b1, 1'b1);
    run_check8("sub_50_20_b1", 8'h2F, 1'b1, 1'b0);
    tick();

    // Start pulsed while busy is ignored
    start_op8(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    a8 = 8'hAA; b8 = 8'hAA; cin8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("ignore_busy_t2", {30'd0, busy8, done8}, 32'h2);
    tick();
    check("ignore_busy_t3", {30'd0, busy8, done8}, 32'h2);
    tick();
    check("ignore_done", {30'd0, busy8, done8}, 32'h1);
    check("ignore_result", {24'd0, sum8}, 32'h46);
    tick();
    check_hold8("ignore_post1", 8'h46, 1'b0, 1'b0);
    tick();
    check_hold8("ignore_post2", 8'h46, 1'b0, 1'b0);

    // Back-to-back: start held in the DONE cycle, next done 5 cycles later
    start_op8(8'h01, 8'h02, 1'b0, 1'b0);
    run_check8("b2b_first", 8'h03, 1'b0, 1'b0);
    start_op8(8'h7F, 8'h01, 1'b0, 1'b0);
    run_check8("b2b_second", 8'h80, 1'b0, 1'b1);
    tick();
    check_hold8("b2b_post", 8'h80, 1'b0, 1'b1);

    // Reset mid-operation aborts immediately
    start_op8(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    Reset_n = 1'b0;
    #1;
    check("abort_outputs", {19'd0, busy8, done8, ovf8, cout8, sum8}, 32'h0);
    tick();
    Reset_n = 1'b1;
    got = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done8 || busy8) got[0] = 1'b1;
    end
    check("abort_no_done", {31'd0, got[0]}, 32'h0);
    start_op8(8'h11, 8'h22, 1'b0, 1'b0);
    run_check8("after_abort", 8'h33, 1'b0, 1'b0);
    tick();

    // Exhaustive 4-bit sweep, all three digit sizes in parallel
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            sa = (ai > 7) ? ai - 16 : ai;
            sb = (bi > 7) ? bi - 16 : bi;
            if (s == 0) begin
              r  = ai + bi + c;
              rs = sa + sb + c;
              exp4 = {(rs > 7 || rs < -8) ? 1'b1 : 1'b0, (r > 15) ? 1'b1 : 1'b0, 4'(r & 15)};
            end else begin
              r  = ai - bi - c;
              rs = sa - sb - c;
              exp4 = {(rs > 7 || rs < -8) ? 1'b1 : 1'b0, (r >= 0) ? 1'b1 : 1'b0, 4'(r & 15)};
            end
            a4 = 4'(ai); b4 = 4'(bi); cin4 = c[0]; sub4 = s[0]; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            got = 3'b000;
            for (int j = 0; j < 3; j++) obs[j] = 6'bxxxxxx;
            for (int k = 0; k < 7 && got != 3'b111; k++) begin
              tick();
              for (int j = 0; j < 3; j++) begin
                if (done4[j] && !got[j]) begin
                  got[j] = 1'b1;
                  obs[j] = {ovf4[j], cout4[j], sum4[j]};
                end
              end
            end
            check("exh_d1", {26'd0, obs[0]}, {26'd0, exp4});
            check("exh_d2", {26'd0, obs[1]}, {26'd0, exp4});
            check("exh_d4", {26'd0, obs[2]}, {26'd0, exp4});
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
